// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU results and FIFO-buffered load results onto the
// register file write port, and flags registers with a write still in flight.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            regwrite,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    input  logic [4:0]      query_reg1,
    input  logic [4:0]      query_reg2,
    output logic            busy1,
    output logic            busy2
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [AW:0]     wptr, rptr, count;
    logic [1:0]      starve_cnt;
    logic            empty, full, alu_hs, mem_hs, pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [DEPTH-1:0] hit1, hit2;

    assign count     = wptr - rptr;
    assign empty     = count == '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign mem_ready = !full;
    assign alu_ready = !(starve_cnt == 2'd3 && !empty);
    assign alu_hs    = alu_valid && alu_ready;
    assign mem_hs    = mem_valid && mem_ready;
    assign pop       = !alu_hs && !empty;
    assign head_rd   = fifo_rd[rptr[AW-1:0]];
    assign head_data = fifo_data[rptr[AW-1:0]];

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        logic [AW-1:0] offset;
        logic          live;
        assign offset  = AW'(s) - rptr[AW-1:0];
        assign live    = {1'b0, offset} < count;
        assign hit1[s] = live && fifo_rd[s] == query_reg1;
        assign hit2[s] = live && fifo_rd[s] == query_reg2;
    end

    assign busy1 = query_reg1 != '0 && (|hit1 || (regwrite && write_reg == query_reg1));
    assign busy2 = query_reg2 != '0 && (|hit2 || (regwrite && write_reg == query_reg2));

    always_ff @(posedge clock) begin
        if (mem_hs) begin
            fifo_rd[wptr[AW-1:0]]   <= mem_rd;
            fifo_data[wptr[AW-1:0]] <= mem_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            starve_cnt <= '0;
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (mem_hs) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            starve_cnt <= (pop || empty) ? 2'd0 : alu_hs ? starve_cnt + 2'd1 : starve_cnt;
            regwrite   <= alu_hs ? alu_rd != '0 : pop && head_rd != '0;
            // x0 results consume their slot but leave the write port holding its last value
            if (alu_hs && alu_rd != '0) begin
                write_reg  <= alu_rd;
                write_data <= alu_data;
            end else if (pop && head_rd != '0) begin
                write_reg  <= head_rd;
                write_data <= head_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized scoreboard bench; a queue-based reference model
// predicts handshakes and write order, a monitor checks every register-file write.
module tb_regfile_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clock = 0;
    logic            reset = 1;
    logic            alu_valid = 0, mem_valid = 0;
    logic            alu_ready, mem_ready, regwrite, busy1, busy2;
    logic [4:0]      alu_rd = 0, mem_rd = 0, write_reg, query_reg1 = 0, query_reg2 = 0;
    logic [XLEN-1:0] alu_data = 0, mem_data = 0, write_data;

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .query_reg1(query_reg1), .query_reg2(query_reg2), .busy1(busy1), .busy2(busy2)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [36:0] lq[$];
    logic [36:0] exp_q[$];
    int          starve = 0;
    logic        out_valid = 0;
    logic [4:0]  out_reg = 0;
    logic [31:0] out_data = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic busy_m(input logic [4:0] q);
        logic b = out_valid && out_reg == q;
        foreach (lq[i]) if (lq[i][36:32] == q) b = 1'b1;
        return q != 0 && b;
    endfunction

    always @(negedge clock) begin
        if (regwrite === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_write", {27'd0, write_reg, write_data}, 64'd0);
            else chk("write_port", {27'd0, write_reg, write_data}, {27'd0, exp_q.pop_front()});
        end
    end

    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] q1, input logic [4:0] q2, output logic mhs);
        logic ar_m, mr_m, ahs, pop, got;
        logic [36:0] prod;
        @(negedge clock);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        query_reg1 = q1; query_reg2 = q2;
        #1;
        ar_m = !(starve == 3 && lq.size() != 0);
        mr_m = lq.size() < DEPTH;
        chk("alu_ready", alu_ready, ar_m);
        chk("mem_ready", mem_ready, mr_m);
        chk("regwrite", regwrite, out_valid);
        chk("write_reg", write_reg, out_reg);
        chk("write_data", write_data, out_data);
        chk("busy1", busy1, busy_m(q1));
        chk("busy2", busy2, busy_m(q2));
        ahs = av && ar_m;
        mhs = mv && mr_m;
        pop = !ahs && lq.size() != 0;
        @(posedge clock);
        starve = (pop || lq.size() == 0) ? 0 : ahs ? starve + 1 : starve;
        got = 1'b1;
        prod = '0;
        if (ahs) prod = {ard, ad};
        else if (pop) prod = lq.pop_front();
        else got = 1'b0;
        if (mhs) lq.push_back({mrd, md});
        out_valid = got && prod[36:32] != 0;
        if (out_valid) begin
            out_reg  = prod[36:32];
            out_data = prod[31:0];
            exp_q.push_back(prod);
        end
    endtask

    task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
        logic m;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, q1, q2, m);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1;
        alu_valid = 0; mem_valid = 0;
        #1;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        lq.delete(); exp_q.delete();
        starve = 0; out_valid = 0; out_reg = 0; out_data = 0;
        @(posedge clock);
        @(negedge clock);
        #2 reset = 0;
    endtask

    initial begin
        logic m;
        int k, n;
        query_reg1 = 5'd3; query_reg2 = 5'd7;
        do_reset();
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, m);
        idle(2, 5, 0);
        cycle(0, 0, 0, 1, 7, 32'h0000_7777, 7, 0, m);
        idle(4, 7, 7);
        k = 1; n = 0;
        while (k <= 5 && n < 40) begin
            cycle(1, 5'($urandom_range(8, 31)), $urandom, 1, 5'(k), 32'h100 + k, 5'(k), 5'(k + 1), m);
            if (m) k++;
            n++;
        end
        chk("loads_pushed", k, 6);
        idle(8, 1, 5);
        cycle(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0, m);
        idle(3, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 5'(9 + i), $urandom, 1, 5'(20 + i), $urandom, 20, 9, m);
        do_reset();
        idle(3, 20, 21);
        cycle(1, 3, 32'hAAAA_0003, 1, 3, 32'hBBBB_0003, 3, 3, m);
        idle(4, 3, 3);
        for (int i = 0; i < 500; i++)
            cycle(($urandom % 4) != 0, 5'($urandom % 8), $urandom, ($urandom % 2) != 0,
                  5'($urandom % 8), $urandom, 5'($urandom % 8), 5'($urandom % 8), m);
        idle(DEPTH + 3, 1, 2);
        chk("drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
